ps2_key_decoder: RTL
====================

Name: ps2_key_decoder

Overview:
- Sits between the PS/2 byte receiver and the title/game fsm.
- Takes raw scan-code bytes from the receiver (set 2, byte + one-cycle strobe) and tracks make, break and extended prefixes.
- Produces the one-cycle start pulse for the fsm, plus held-key flags for gameplay movement.
- Suppresses typematic repeats, so one physical press gives exactly one start pulse.

Parameters:
- TIMEOUT_CYCLES, 26'd2500000, prefix timeout in clock cycles (50 ms at 50 MHz); used only with the optional feature.

Ports:
- clock  input  1  system clock (CLOCK_50)
- resetn  input  1  asynchronous active-low reset
- ps2_byte  input  8  received scan-code byte
- ps2_byte_en  input  1  one-cycle strobe; ps2_byte is valid this cycle
- start  output  1  one-cycle pulse on an Enter press
- key_up  output  1  held: W (1D) or E0 75
- key_down  output  1  held: S (1B) or E0 72
- key_left  output  1  held: A (1C) or E0 6B
- key_right  output  1  held: D (23) or E0 74
- key_fire  output  1  held: Space (29)
- last_code  output  8  last non-prefix byte decoded
- last_ext  output  1  last_code was preceded by E0

Behaviour:
- Reset values: all outputs 0 and state IDLE. Reset is asynchronous and may occur mid-sequence; any pending prefix is discarded.
- Bytes are consumed only when ps2_byte_en = 1. Otherwise the state holds.
- States:
  - IDLE
  - EXT (after E0)
  - BRK (after F0)
  - EXT_BRK (after E0 F0)
- Transitions on a strobe:
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte -> decode as a make code, stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> EXT (repeated prefix ignored); other byte -> extended make, go to IDLE.
  - BRK: any byte except E0/F0 -> break, go to IDLE. E0 or F0 -> treat as a malformed sequence and restart: E0 -> EXT, F0 -> BRK.
  - EXT_BRK: any byte except E0/F0 -> extended break, go to IDLE. E0 -> EXT; F0 -> EXT_BRK.
- Make: set the matching held flag. Break: clear it.
- Key-class rules:
  - Non-extended codes match only the W/A/S/D/Space mappings.
  - Extended codes match only the arrow mappings.
  - Enter is 5A plain or extended (keypad Enter).
- An unmapped code changes no flag but still updates last_code and last_ext.
- All outputs are registered. Every flag, last_code and last_ext update on the clock edge after the strobe (latency 1).
- start logic:
  - An internal enter_held register is set on an Enter make and cleared on an Enter break.
  - start = 1 for exactly one cycle, the cycle after the strobe, only if enter_held was 0 before the make.
  - Typematic repeats (repeated 5A makes with no break) produce no further pulse.
- Independent flags may be held at the same time, e.g. key_up and key_left together. Both W and E0 75 drive key_up; a break of either one clears it (no reference counting).
- E0 12 / E0 F0 12 (print-screen fake shift) decode as unmapped extended codes with no side effects.
- A strobe received in the same cycle as resetn asserting is discarded.

Optional Feature:
- Macro: PS2_PREFIX_TIMEOUT_EN.
- Defined:
  - A 26-bit down-counter loads TIMEOUT_CYCLES whenever the state enters EXT, BRK or EXT_BRK, and reloads on each strobe.
  - If it reaches 0 while not in IDLE, the state returns to IDLE without decoding a key.
  - The counter is reset to 0 asynchronously.
- Not defined: no counter; a prefix waits indefinitely for its next byte.

Test Plan:
- Reset then 5A: strobe 5A -> start = 1 for exactly one cycle (cycle after strobe); last_code = 5A, last_ext = 0.
- Typematic repeat: 5A, 5A, 5A, then F0 5A, then 5A -> exactly 2 start pulses in total; no pulse on the break.
- Extended arrows: E0 75, E0 6B -> key_up = 1 and key_left = 1. Then E0 F0 75 -> key_up = 0, key_left remains 1, last_ext = 1.
- Shared flag: 1D, then E0 75, then F0 1D -> key_up = 0 after the break; keypad E0 5A -> start pulse.
- Malformed and reset: F0 then E0 then 74 -> key_right = 1 (the F0 is abandoned). Pulsing resetn low mid-sequence (after E0), then 29 -> key_fire = 1, last_ext = 0.
- With PS2_PREFIX_TIMEOUT_EN and TIMEOUT_CYCLES = 100: send F0, wait 101 cycles, send 1D -> key_up = 1 (the byte is treated as a make). Without the macro, the same stimulus gives key_up = 0.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder: tracks E0/F0 prefixes, holds movement flags, pulses start on Enter press.
// Optional prefix timeout is compiled in with `define PS2_PREFIX_TIMEOUT_EN.
module ps2_key_decoder #(
    parameter logic [25:0] TIMEOUT_CYCLES = 26'd2500000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] ps2_byte,
    input  logic       ps2_byte_en,
    output logic       start,
    output logic       key_up,
    output logic       key_down,
    output logic       key_left,
    output logic       key_right,
    output logic       key_fire,
    output logic [7:0] last_code,
    output logic       last_ext
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t state;
    state_t state_next;
    logic   dec_valid;
    logic   dec_ext;
    logic   dec_brk;
    logic   make;
    logic   enter_held;

`ifdef PS2_PREFIX_TIMEOUT_EN
    logic [25:0] timeout_cnt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            timeout_cnt <= 26'd0;
        end else if (ps2_byte_en) begin
            timeout_cnt <= TIMEOUT_CYCLES;
        end else if (timeout_cnt != 26'd0) begin
            timeout_cnt <= timeout_cnt - 26'd1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Prefix bytes always restart the sequence; an F0 keeps the extended flavour if one is pending.
    always_comb begin
        state_next = state;
        dec_valid  = 1'b0;
        dec_ext    = 1'b0;
        dec_brk    = 1'b0;
        if (ps2_byte_en) begin
            if (ps2_byte == 8'hE0) begin
                state_next = EXT;
            end else if (ps2_byte == 8'hF0) begin
                state_next = (state == EXT || state == EXT_BRK) ? EXT_BRK : BRK;
            end else begin
                dec_valid  = 1'b1;
                dec_ext    = (state == EXT) || (state == EXT_BRK);
                dec_brk    = (state == BRK) || (state == EXT_BRK);
                state_next = IDLE;
            end
        end
`ifdef PS2_PREFIX_TIMEOUT_EN
        else if (timeout_cnt == 26'd0 && state != IDLE) begin
            state_next = IDLE;
        end
`endif
    end

    assign make = !dec_brk;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            start      <= 1'b0;
            enter_held <= 1'b0;
            key_up     <= 1'b0;
            key_down   <= 1'b0;
            key_left   <= 1'b0;
            key_right  <= 1'b0;
            key_fire   <= 1'b0;
            last_code  <= 8'h00;
            last_ext   <= 1'b0;
        end else begin
            start <= 1'b0;
            if (dec_valid) begin
                last_code <= ps2_byte;
                last_ext  <= dec_ext;
                // Enter (main or keypad); enter_held masks typematic repeats.
                if (ps2_byte == 8'h5A) begin
                    enter_held <= make;
                    start      <= make && !enter_held;
                end
                if (!dec_ext) begin
                    case (ps2_byte)
                        8'h1D:   key_up    <= make;
                        8'h1B:   key_down  <= make;
                        8'h1C:   key_left  <= make;
                        8'h23:   key_right <= make;
                        8'h29:   key_fire  <= make;
                        default: ;
                    endcase
                end else begin
                    case (ps2_byte)
                        8'h75:   key_up    <= make;
                        8'h72:   key_down  <= make;
                        8'h6B:   key_left  <= make;
                        8'h74:   key_right <= make;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
